// File: rtl/uart_tx_engine_pkg.sv
// ---------------------------------------------------------------------------
// uart_define
// Shared definitions for the UART transmit path: the transmit FSM state
// encoding, the data-width and parity-type codes used by the register block,
// the latched frame descriptor, and small helpers for the frame layout.
// No ports (package).
// ---------------------------------------------------------------------------
package uart_define;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

    // data_bit_num encoding
    localparam logic [1:0] DATA_BITS_5 = 2'd0;
    localparam logic [1:0] DATA_BITS_6 = 2'd1;
    localparam logic [1:0] DATA_BITS_7 = 2'd2;
    localparam logic [1:0] DATA_BITS_8 = 2'd3;

    // parity_type encoding
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Everything about one frame, captured at request time so that later
    // register writes cannot disturb a frame in flight.
    typedef struct packed {
        logic [7:0] data;
        logic [1:0] data_bit_num;
        logic       stop_bit_num;
        logic       parity_en;
        logic       parity_type;
    } uart_data_frame_t;

    // Index of the last data bit for a given width code.
    function automatic logic [2:0] last_data_idx(input logic [1:0] code);
        logic [2:0] idx;
        case (code)
            DATA_BITS_5: idx = 3'd4;
            DATA_BITS_6: idx = 3'd5;
            DATA_BITS_7: idx = 3'd6;
            default:     idx = 3'd7;
        endcase
        return idx;
    endfunction

    // Parity over only the bits actually transmitted.
    function automatic logic calc_parity(input logic [7:0] data,
                                         input logic [1:0] code,
                                         input logic       ptype);
        logic [7:0] mask;
        logic       p;
        mask = 8'hFF >> (DATA_BITS_8 - code);
        p    = ^(data & mask);
        if (ptype == PARITY_ODD) begin
            p = ~p;
        end
        return p;
    endfunction

endpackage

// File: rtl/uart_tx_engine_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Bit-period timer for the UART transmitter. Counts 0..CLKS_PER_BIT-1 and
// wraps; cleared to 0 on the frame launch edge so every frame starts with a
// full-length start bit.
// Ports:
//   i_clk       system clock
//   i_reset     asynchronous active-high reset
//   i_clear     restart the bit period (frame launch)
//   o_bit_tick  high during the last cycle of a bit period
//   o_pre_tick  high during the next-to-last cycle of a bit period
// ---------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_bit_tick,
    output logic o_pre_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST_COUNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE_COUNT  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] r_count;

    // Free-running bit-period counter; the launch clear wins over wrapping.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear || (r_count == LAST_COUNT)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // The pre-tick lets the FSM register tx_done so it lands on the final cycle.
    assign o_bit_tick = (r_count == LAST_COUNT);
    assign o_pre_tick = (r_count == PRE_COUNT);

endmodule

// File: rtl/uart_tx_engine.sv
// ---------------------------------------------------------------------------
// uart_tx_engine
// UART transmit serializer. Accepts a byte on i_start_tx, frames it as
// start bit, 5-8 data bits LSB first, optional parity and 1 or 2 stop bits,
// and shifts it out at CLKS_PER_BIT clocks per bit. A frame launches only
// while i_cts_n is low.
// Ports:
//   i_clk, i_reset    clock / asynchronous active-high reset
//   i_start_tx        transmit request (pulse or level)
//   i_tx_data[7:0]    byte to send (bits above data width ignored)
//   i_data_bit_num    0:5 1:6 2:7 3:8 data bits
//   i_stop_bit_num    0:one stop bit 1:two
//   i_parity_en       append parity bit
//   i_parity_type     0:even 1:odd
//   i_cts_n           clear-to-send, active low, sampled only at launch
//   o_tx              registered serial line, idle high
//   o_tx_done         one-cycle pulse on the last cycle of the final stop bit
//   o_tx_busy         high from accepted request through end of frame
// ---------------------------------------------------------------------------
module uart_tx_engine
    import uart_define::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start_tx,
    input  logic [7:0] i_tx_data,
    input  logic [1:0] i_data_bit_num,
    input  logic       i_stop_bit_num,
    input  logic       i_parity_en,
    input  logic       i_parity_type,
    input  logic       i_cts_n,
    output logic       o_tx,
    output logic       o_tx_done,
    output logic       o_tx_busy
);

    uart_tx_state_e   r_state;
    uart_data_frame_t r_frame;
    logic             r_parity_bit;
    logic [2:0]       r_bit_cnt;
    logic             r_stop_cnt;
    logic             r_pending;
    logic             r_tx;
    logic             r_tx_done;
    logic             r_tx_busy;

    logic w_launch;
    logic w_bit_tick;
    logic w_pre_tick;
    logic w_last_stop;
    logic w_last_data;

    // A held request (pending) or a fresh one both launch once CTS is asserted.
    assign w_launch    = (r_state == IDLE) && (i_start_tx || r_pending) && !i_cts_n;
    assign w_last_stop = (r_stop_cnt == r_frame.stop_bit_num);
    assign w_last_data = (r_bit_cnt == last_data_idx(r_frame.data_bit_num));

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (w_launch),
        .o_bit_tick (w_bit_tick),
        .o_pre_tick (w_pre_tick)
    );

    // Frame sequencer. Every output is registered here; the line value for
    // the next bit is loaded on the tick that ends the current bit. The data
    // field of r_frame doubles as the shift register once the frame starts.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_frame      <= '{data: 8'h00, data_bit_num: DATA_BITS_8, stop_bit_num: 1'b0,
                              parity_en: 1'b0, parity_type: PARITY_EVEN};
            r_parity_bit <= 1'b0;
            r_bit_cnt    <= 3'd0;
            r_stop_cnt   <= 1'b0;
            r_pending    <= 1'b0;
            r_tx         <= 1'b1;
            r_tx_done    <= 1'b0;
            r_tx_busy    <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    // A new request while waiting on CTS replaces the held one.
                    if (i_start_tx) begin
                        r_frame      <= '{data: i_tx_data, data_bit_num: i_data_bit_num,
                                          stop_bit_num: i_stop_bit_num,
                                          parity_en: i_parity_en, parity_type: i_parity_type};
                        r_parity_bit <= calc_parity(i_tx_data, i_data_bit_num, i_parity_type);
                    end
                    if (w_launch) begin
                        r_state   <= START;
                        r_tx      <= 1'b0;
                        r_tx_busy <= 1'b1;
                        r_pending <= 1'b0;
                    end else if (i_start_tx) begin
                        r_pending <= 1'b1;
                        r_tx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (w_bit_tick) begin
                        r_state      <= DATA;
                        r_tx         <= r_frame.data[0];
                        r_frame.data <= r_frame.data >> 1;
                        r_bit_cnt    <= 3'd0;
                    end
                end
                DATA: begin
                    if (w_bit_tick) begin
                        if (w_last_data) begin
                            if (r_frame.parity_en) begin
                                r_state <= PARITY;
                                r_tx    <= r_parity_bit;
                            end else begin
                                r_state    <= STOP;
                                r_tx       <= 1'b1;
                                r_stop_cnt <= 1'b0;
                            end
                        end else begin
                            r_bit_cnt    <= r_bit_cnt + 3'd1;
                            r_tx         <= r_frame.data[0];
                            r_frame.data <= r_frame.data >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (w_bit_tick) begin
                        r_state    <= STOP;
                        r_tx       <= 1'b1;
                        r_stop_cnt <= 1'b0;
                    end
                end
                STOP: begin
                    if (w_pre_tick && w_last_stop) begin
                        r_tx_done <= 1'b1;
                    end
                    if (w_bit_tick) begin
                        if (w_last_stop) begin
                            r_state   <= IDLE;
                            r_tx_busy <= 1'b0;
                        end else begin
                            r_stop_cnt <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign o_tx      = r_tx;
    assign o_tx_done = r_tx_done;
    assign o_tx_busy = r_tx_busy;

endmodule

// File: tb/tb_uart_tx_engine.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_uart_tx_engine
// Self-checking bench for uart_tx_engine. The reference model expands each
// requested byte into the list of line levels for every bit period of the
// frame; the expected line value in any cycle is simply that list indexed by
// cycle / CLKS_PER_BIT.
// ---------------------------------------------------------------------------
module tb_uart_tx_engine;

    localparam int CLKS_PER_BIT = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       startTx;
    logic [7:0] txData;
    logic [1:0] dataBitNum;
    logic       stopBitNum;
    logic       parityEn;
    logic       parityType;
    logic       ctsN;
    logic       tx;
    logic       txDone;
    logic       txBusy;

    int errorCount = 0;
    int checkCount = 0;
    bit expBits[$];

    uart_tx_engine #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) dut (
        .i_clk          (clock),
        .i_reset        (reset),
        .i_start_tx     (startTx),
        .i_tx_data      (txData),
        .i_data_bit_num (dataBitNum),
        .i_stop_bit_num (stopBitNum),
        .i_parity_en    (parityEn),
        .i_parity_type  (parityType),
        .i_cts_n        (ctsN),
        .o_tx           (tx),
        .o_tx_done      (txDone),
        .o_tx_busy      (txBusy)
    );

    // Free-running clock, 10 ns period.
    always #5 clock = ~clock;

    // Hard stop in case something wedges the run.
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Reference model: list of line levels, one entry per bit period.
    task automatic buildFrame(input logic [7:0] data, input logic [1:0] dbn,
                              input logic sbn, input logic pen, input logic ptype);
        int n;
        int ones;
        n    = int'(dbn) + 5;
        ones = 0;
        expBits.delete();
        expBits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            expBits.push_back(data[i]);
            ones += int'(data[i]);
        end
        if (pen) begin
            // Odd parity makes the total count of ones odd; even makes it even.
            if (ptype) expBits.push_back((ones % 2) == 0);
            else       expBits.push_back((ones % 2) == 1);
        end
        expBits.push_back(1'b1);
        if (sbn) expBits.push_back(1'b1);
    endtask

    // Drive a request; called at a falling edge so the next rising edge samples it.
    task automatic applyStimulus(input logic [7:0] data, input logic [1:0] dbn,
                                 input logic sbn, input logic pen, input logic ptype,
                                 input logic cts);
        txData     = data;
        dataBitNum = dbn;
        stopBitNum = sbn;
        parityEn   = pen;
        parityType = ptype;
        ctsN       = cts;
        startTx    = 1'b1;
    endtask

    // Walks one whole frame cycle by cycle against expBits, then checks the
    // single idle cycle that follows. With disturb set, inputs are scrambled
    // during the frame (extra start_tx pulses, new data/config, CTS toggles).
    task automatic checkFrame(input string name, input bit disturb);
        int len;
        len = expBits.size() * CLKS_PER_BIT;
        for (int c = 0; c < len; c++) begin
            @(negedge clock);
            checkOutput($sformatf("%s tx c%0d", name, c), 32'(tx), 32'(expBits[c / CLKS_PER_BIT]));
            checkOutput($sformatf("%s done c%0d", name, c), 32'(txDone), 32'(c == len - 1));
            checkOutput($sformatf("%s busy c%0d", name, c), 32'(txBusy), 32'd1);
            if (disturb) begin
                startTx    = ($urandom_range(0, 11) == 0);
                txData     = 8'($urandom);
                dataBitNum = 2'($urandom);
                stopBitNum = 1'($urandom);
                parityEn   = 1'($urandom);
                parityType = 1'($urandom);
                ctsN       = 1'($urandom);
            end else begin
                startTx = 1'b0;
            end
        end
        @(negedge clock);
        checkOutput($sformatf("%s idle tx", name), 32'(tx), 32'd1);
        checkOutput($sformatf("%s idle done", name), 32'(txDone), 32'd0);
        checkOutput($sformatf("%s idle busy", name), 32'(txBusy), 32'd0);
        startTx = 1'b0;
        ctsN    = 1'b0;
    endtask

    // Check the line stays idle for a number of cycles.
    task automatic checkIdle(input string name, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clock);
            checkOutput($sformatf("%s tx", name), 32'(tx), 32'd1);
            checkOutput($sformatf("%s done", name), 32'(txDone), 32'd0);
            checkOutput($sformatf("%s busy", name), 32'(txBusy), 32'd0);
        end
    endtask

    // Directed frame: request and walk it through.
    task automatic runFrame(input string name, input logic [7:0] data, input logic [1:0] dbn,
                            input logic sbn, input logic pen, input logic ptype,
                            input bit disturb);
        buildFrame(data, dbn, sbn, pen, ptype);
        applyStimulus(data, dbn, sbn, pen, ptype, 1'b0);
        checkFrame(name, disturb);
    endtask

    initial begin
        logic [7:0] rData;
        logic [1:0] rDbn;
        logic       rSbn;
        logic       rPen;
        logic       rPtype;

        reset      = 1'b1;
        startTx    = 1'b0;
        txData     = 8'h00;
        dataBitNum = 2'd3;
        stopBitNum = 1'b0;
        parityEn   = 1'b0;
        parityType = 1'b0;
        ctsN       = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        checkOutput("reset tx", 32'(tx), 32'd1);
        checkOutput("reset done", 32'(txDone), 32'd0);
        checkOutput("reset busy", 32'(txBusy), 32'd0);
        reset = 1'b0;
        checkIdle("post reset", 4);

        // Directed frames
        runFrame("8N1 A5", 8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        runFrame("7E2 35", 8'h35, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        runFrame("5O1 FF", 8'hFF, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        runFrame("5O1 1F", 8'h1F, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        runFrame("6O2 2A", 8'h2A, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1);

        // Back-to-back: the second request lands in the single idle cycle
        runFrame("b2b 55", 8'h55, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        runFrame("b2b 0F", 8'h0F, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);

        // CTS held off: request is held, then replaced, then launched
        applyStimulus(8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int c = 1; c < 25; c++) begin
            @(negedge clock);
            checkOutput($sformatf("cts hold tx c%0d", c), 32'(tx), 32'd1);
            checkOutput($sformatf("cts hold busy c%0d", c), 32'(txBusy), 32'd1);
            checkOutput($sformatf("cts hold done c%0d", c), 32'(txDone), 32'd0);
            startTx = 1'b0;
        end
        applyStimulus(8'hC6, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int c = 25; c < 50; c++) begin
            @(negedge clock);
            checkOutput($sformatf("cts relatch tx c%0d", c), 32'(tx), 32'd1);
            checkOutput($sformatf("cts relatch busy c%0d", c), 32'(txBusy), 32'd1);
            startTx = 1'b0;
        end
        buildFrame(8'hC6, 2'd2, 1'b1, 1'b1, 1'b1);
        ctsN = 1'b0;
        checkFrame("cts release", 1'b1);

        // Randomized frames, scrambled inputs mid-frame, random idle gaps
        for (int f = 0; f < 20; f++) begin
            rData  = 8'($urandom);
            rDbn   = 2'($urandom);
            rSbn   = 1'($urandom);
            rPen   = 1'($urandom);
            rPtype = 1'($urandom);
            runFrame($sformatf("rand%0d", f), rData, rDbn, rSbn, rPen, rPtype, 1'b1);
            if ($urandom_range(0, 2) == 0) begin
                checkIdle($sformatf("gap%0d", f), int'($urandom_range(1, 6)));
            end
        end

        // Reset mid-DATA: line returns high at once, no frame afterwards
        buildFrame(8'hC3, 2'd3, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hC3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c <= 40; c++) begin
            @(negedge clock);
            checkOutput($sformatf("pre-reset tx c%0d", c), 32'(tx), 32'(expBits[c / CLKS_PER_BIT]));
            startTx = 1'b0;
        end
        reset = 1'b1;
        #1;
        checkOutput("mid reset tx", 32'(tx), 32'd1);
        checkOutput("mid reset busy", 32'(txBusy), 32'd0);
        checkOutput("mid reset done", 32'(txDone), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        checkIdle("after mid reset", 250);

        // Reset drops a request held back by CTS
        applyStimulus(8'h81, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        checkOutput("pending busy", 32'(txBusy), 32'd1);
        startTx = 1'b0;
        reset   = 1'b1;
        #1;
        checkOutput("pending reset busy", 32'(txBusy), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        ctsN  = 1'b0;
        checkIdle("pending dropped", 100);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
